pipe_stage: RTL
===============

# pipe_stage

Parametrised pipeline stage register that generalises the fixed 32-bit fetch/decode latch into a configurable-width stage with a valid/ready handshake, flush, hazard hold and a saturating stall counter. It sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Bubbles are expressed by a valid bit, not only by a zeroed payload. An optional 2-entry skid buffer breaks the combinational ready path.

## Interface
Parameters:
- DATA_W, 64, payload width (e.g. PC + instruction)
- BUBBLE_VAL, {DATA_W{1'b0}}, value driven on out_data when the stage is empty or flushed
- CNT_W, 16, width of stall_cnt

Ports:
- clk  in  1  single clock, all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream has a payload
- in_ready  out  1  stage accepts; transfer happens when in_valid && in_ready
- in_data  in  DATA_W  upstream payload
- flush  in  1  discard all held entries (branch taken / exception)
- hold  in  1  hazard freeze: contents kept, no transfer on either side
- out_valid  out  1  payload presented downstream
- out_ready  in  1  downstream accepts; transfer when out_valid && out_ready
- out_data  out  DATA_W  presented payload
- stall_cnt  out  CNT_W  saturating count of backpressure cycles

## Operation
- Priority per cycle: rst > flush > hold > normal handshake.
- rst: all entries invalid, data = BUBBLE_VAL, stall_cnt = 0.
- flush: next state all entries invalid, data = BUBBLE_VAL. in_ready forced 0 in that cycle, so an offered payload is not consumed and no payload is lost silently.
- hold (flush = 0): all registers unchanged. in_ready = 0 and out_valid = 0, both combinational. A held payload is re-presented when hold drops.
- Normal, single entry: in_ready = !hold && !flush && (!valid || out_ready).
  - Accept: register loads in_data, valid = 1.
  - Drain only (out fires, no accept): valid = 0, data = BUBBLE_VAL.
  - Accept and drain in the same cycle: back-to-back pass, one payload per cycle.
- out_data always comes from the register; it equals BUBBLE_VAL whenever the stage is empty.
- stall_cnt increments when out_valid && !out_ready. It saturates at all-ones and does not change during hold or flush.
- Ordering: payloads leave in arrival order. No duplication and no drops except via flush.

## Timing
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 transfer per cycle while out_ready = 1.
- After rst deasserts, in_ready = 1 on the first cycle (hold = 0, flush = 0). out_valid = 0.
- Without skid: in_ready depends combinationally on out_ready, hold and flush.
- With skid: see Configuration. The out_ready→in_ready path is registered; hold/flush still gate in_ready combinationally.
- A flush in the same cycle as a drain: the drain completes downstream (out_valid was 1 with out_ready), then the stage is empty the next cycle.
- A hold asserted mid-backpressure freezes both entries; the stall count pauses.

## Configuration
- PIPE_STAGE_SKID_EN defined: a second "skid" entry is instantiated.
  - in_ready = !skid_valid && !hold && !flush, where skid_valid is registered.
  - An input accepted while out_ready = 0 and the main entry is full goes to skid.
  - When main drains, skid moves into main the next cycle. Up to 2 payloads are buffered.
  - Flush clears both entries; hold freezes both.
- PIPE_STAGE_SKID_EN undefined: single entry, combinational in_ready as in Operation. Port list is identical in both builds.

## Structure
- Shared package pipe_pkg:
  - default stall counter width constant
  - payload struct typedefs per stage (if_id_t: pc[31:0], instr[31:0]), so DATA_W = $bits(if_id_t)
  - bubble constants per stage
- One sub-module, pipe_skid_buf: the 2-entry main/skid storage with its handshake. It is instantiated only under PIPE_STAGE_SKID_EN. pipe_stage keeps the flush/hold gating and stall_cnt.

## Test plan
- Reset: rst = 1 for 2 cycles with in_valid = 1, in_data = 64'hDEAD -> out_valid = 0, out_data = 0, stall_cnt = 0; in_ready = 1 on the first cycle after release.
- Streaming: 8 payloads 1..8 with out_ready = 1 -> out_data = 1..8 on consecutive cycles, 1-cycle latency, none dropped.
- Backpressure: load 5, hold out_ready = 0 for 4 cycles while offering 6 and 7 -> stall_cnt = 4 and 5 stays presented. Without skid, in_ready = 0; with skid, 6 is accepted and 7 is refused. Release out_ready -> 5, 6, 7 in order.
- Flush: stage full with 9 (and skid with 10), flush = 1 with in_valid = 1, in_data = 11 -> in_ready = 0 that cycle, then out_valid = 0, out_data = 0; 11 is accepted on the following cycle.
- Hold: stage holds 12, hold = 1 for 3 cycles with out_ready = 1 and in_valid = 1 -> out_valid = 0, in_ready = 0, stall_cnt unchanged; after release 12 is presented exactly once.
- Saturation: CNT_W = 4, out_ready = 0 for 20 cycles with valid data -> stall_cnt stops at 15.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: default counter width, per-stage payload
// structs and their bubble values.
package pipe_pkg;

    localparam int STALL_CNT_W = 16;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    localparam int IF_ID_W = $bits(if_id_t);

    // RISC-V canonical NOP (addi x0, x0, 0) for stages that prefer a decodable bubble.
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam if_id_t      IF_ID_BUBBLE = '{pc: 32'h0, instr: 32'h0};
    localparam if_id_t      IF_ID_NOP    = '{pc: 32'h0, instr: NOP_INSTR};

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry main/skid storage. The parent gates push/pop with hold and flush,
// so a frozen stage simply sees neither.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int                DATA_W     = IF_ID_W,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              main_valid,
    output logic [DATA_W-1:0] main_data,
    output logic              skid_valid
);

    logic [DATA_W-1:0] skid_data;

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            main_valid <= 1'b0;
            main_data  <= BUBBLE_VAL;
            skid_valid <= 1'b0;
            skid_data  <= BUBBLE_VAL;
        end else if (skid_valid) begin
            // Input is refused while skid is occupied, so only a drain can happen here.
            if (pop) begin
                main_data  <= skid_data;
                skid_valid <= 1'b0;
                skid_data  <= BUBBLE_VAL;
            end
        end else if (main_valid) begin
            if (push && pop) begin
                main_data <= push_data;
            end else if (push) begin
                skid_valid <= 1'b1;
                skid_data  <= push_data;
            end else if (pop) begin
                main_valid <= 1'b0;
                main_data  <= BUBBLE_VAL;
            end
        end else if (push) begin
            main_valid <= 1'b1;
            main_data  <= push_data;
        end
    end

endmodule

// File: rtl/pipe_stage.sv
// Pipeline stage register with valid/ready handshake, flush, hazard hold and a
// saturating stall counter. Define PIPE_STAGE_SKID_EN for the 2-entry skid buffer.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int                DATA_W     = IF_ID_W,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}},
    parameter int                CNT_W      = STALL_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    input  logic              hold,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic              in_fire;
    logic              out_fire;

`ifdef PIPE_STAGE_SKID_EN
    logic skid_valid;

    // Registered skid_valid cuts the out_ready -> in_ready path.
    assign in_ready = !skid_valid && !hold && !flush;

    pipe_skid_buf #(
        .DATA_W     (DATA_W),
        .BUBBLE_VAL (BUBBLE_VAL)
    ) u_skid_buf (
        .clk        (clk),
        .rst        (rst),
        .clear      (flush),
        .push       (in_fire),
        .push_data  (in_data),
        .pop        (out_fire),
        .main_valid (main_valid),
        .main_data  (main_data),
        .skid_valid (skid_valid)
    );
`else
    assign in_ready = !hold && !flush && (!main_valid || out_ready);

    // NOTE: the data register is reset as well, so out_data shows BUBBLE_VAL while empty.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            main_valid <= 1'b0;
            main_data  <= BUBBLE_VAL;
        end else if (in_fire) begin
            main_valid <= 1'b1;
            main_data  <= in_data;
        end else if (out_fire) begin
            main_valid <= 1'b0;
            main_data  <= BUBBLE_VAL;
        end
    end
`endif

    assign out_valid = main_valid && !hold;
    assign out_data  = main_data;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (!flush && out_valid && !out_ready && stall_cnt != CNT_MAX) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
